instr_fetch: RTL and testbench

//  Fetch stage directly upstream of the instruction decoder. Holds the PC, issues word reads to

---
 rtl/rv_pkg.sv | 15 +
 rtl/fetch_skid_buf.sv | 38 +++
 rtl/instr_fetch.sv | 138 +++++++++++++
 tb/tb_instr_fetch.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: constants and types shared by the fetch stage and the decoder.
package rv_pkg;
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {instr, pc} buffer catching a response while decode stalls.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        empty,
    output logic [31:0] skid_instr,
    output logic [31:0] skid_pc
);
    logic        full_q, full_d;
    logic [31:0] instr_q, instr_d, pc_q, pc_d;

    always_comb begin
        full_d  = flush ? 1'b0 : load ? 1'b1 : pop ? 1'b0 : full_q;
        instr_d = load ? load_instr : instr_q;
        pc_d    = load ? load_pc : pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            full_q  <= full_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign empty      = ~full_q;
    assign skid_instr = instr_q;
    assign skid_pc    = pc_q;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, single-outstanding imem request FSM and registered output slot to decode.
module instr_fetch
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);
    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d, addr_q, addr_d, instr_q, instr_d, ipc_q, ipc_d;
    logic         req_q, req_d, valid_q, valid_d;
    logic         flush, slot_free, skid_load, skid_pop, skid_empty;
    logic [31:0]  rpc, pc_inc, skid_instr, skid_pc;

    assign rpc       = redirect_pc & ~32'h3;
    assign pc_inc    = pc_q + 32'd4;
    assign flush     = redirect && state_q != IDLE;
    assign slot_free = ~valid_q | instr_ready;

    fetch_skid_buf u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .pop        (skid_pop),
        .flush      (flush),
        .load_instr (imem_rdata),
        .load_pc    (pc_q),
        .empty      (skid_empty),
        .skid_instr (skid_instr),
        .skid_pc    (skid_pc)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_d     = req_q;
        addr_d    = addr_q;
        valid_d   = valid_q & ~instr_ready;
        instr_d   = (valid_q & instr_ready) ? NOP_INSTR : instr_q;
        ipc_d     = ipc_q;
        skid_load = 1'b0;
        skid_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = WAIT;
                req_d   = 1'b1;
                pc_d    = redirect ? rpc : pc_q;
                addr_d  = pc_d;
            end
            WAIT: begin
                if (redirect) begin
                    // a response arriving with the redirect is wrong-path and simply dropped
                    state_d = imem_rvalid ? WAIT : DROP;
                    pc_d    = rpc;
                    addr_d  = imem_rvalid ? rpc : addr_q;
                end else if (imem_rvalid) begin
                    pc_d = pc_inc;
                    if (slot_free) begin
                        valid_d = 1'b1;
                        instr_d = imem_rdata;
                        ipc_d   = pc_q;
                        addr_d  = pc_inc;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                        req_d     = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_d = WAIT;
                    pc_d    = rpc;
                    req_d   = 1'b1;
                    addr_d  = rpc;
                end else if (instr_ready && !skid_empty) begin
                    skid_pop = 1'b1;
                    valid_d  = 1'b1;
                    instr_d  = skid_instr;
                    ipc_d    = skid_pc;
                    state_d  = WAIT;
                    req_d    = 1'b1;
                    addr_d   = pc_q;
                end
            end
            DROP: begin
                pc_d = redirect ? rpc : pc_q;
                if (imem_rvalid) begin
                    state_d = WAIT;
                    addr_d  = pc_d;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            ipc_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of instr_fetch against a latency-configurable memory model.
module tb_instr_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req, imem_rvalid, instr_valid;
    logic [31:0] imem_addr, imem_rdata, instr, instr_pc;
    logic        instr_ready = 1'b1;
    logic        req2, rv2, v2;
    logic [31:0] addr2, rd2, in2, pc2;

    int          lat = 1;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] q_pc[$];
    logic [31:0] q_in[$];
    logic [31:0] s_in, s_pc;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (1'b0),
        .redirect_pc (32'h0),
        .imem_req    (req2),
        .imem_addr   (addr2),
        .imem_rvalid (rv2),
        .imem_rdata  (rd2),
        .instr_valid (v2),
        .instr       (in2),
        .instr_pc    (pc2),
        .instr_ready (1'b1)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h0050_0093 ^ (a << 12);
    endfunction

    // memory: accepts a request, answers after lat cycles, one rvalid pulse per request
    logic        busy;
    int          cnt;
    logic [31:0] maddr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
            busy        <= 1'b0;
            cnt         <= 0;
            maddr       <= '0;
        end else if (imem_rvalid) begin
            imem_rvalid <= 1'b0;
            busy        <= 1'b0;
        end else if (busy) begin
            if (cnt <= 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= mem(maddr);
            end else cnt <= cnt - 1;
        end else if (imem_req) begin
            busy  <= 1'b1;
            maddr <= imem_addr;
            cnt   <= lat - 1;
            if (lat <= 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= mem(imem_addr);
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv2 <= 1'b0;
            rd2 <= '0;
        end else if (rv2) rv2 <= 1'b0;
        else if (req2) begin
            rv2 <= 1'b1;
            rd2 <= mem(addr2);
        end
    end

    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            q_pc.push_back(instr_pc);
            q_in.push_back(instr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        q_pc.delete();
        q_in.delete();
    endtask

    task automatic wait_q(input int n);
        for (int i = 0; i < 200 && q_pc.size() < n; i++) step();
        chk("queue_fill", 32'(q_pc.size() >= n), 32'd1);
    endtask

    initial begin
        #1;
        step();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", instr_pc, 32'h0);

        // sequential fetch, 1-cycle memory
        lat = 1;
        instr_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 50 && !instr_valid; i++) step();
        chk("t1_valid", 32'(instr_valid), 32'd1);
        chk("t1_instr", instr, 32'h0050_0093);
        chk("t1_ipc", instr_pc, 32'h0);
        chk("t1_next_addr", imem_addr, 32'h4);
        chk("t1_next_req", 32'(imem_req), 32'd1);
        wait_q(4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_seq_pc", q_pc[i], 32'(4 * i));
            chk("t1_seq_in", q_in[i], mem(32'(4 * i)));
        end

        // decode stall fills the skid, fetch pauses in HOLD
        instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 50 && !instr_valid; i++) step();
        chk("t2_valid", 32'(instr_valid), 32'd1);
        s_in = instr;
        s_pc = instr_pc;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_stable_in", instr, s_in);
            chk("t2_stable_pc", instr_pc, s_pc);
        end
        chk("t2_hold_req", 32'(imem_req), 32'd0);
        instr_ready = 1'b1;
        wait_q(3);
        for (int i = 0; i < 3; i++) begin
            chk("t2_order_pc", q_pc[i], 32'(4 * i));
            chk("t2_order_in", q_in[i], mem(32'(4 * i)));
        end

        // redirect with request @8 outstanding, 3-cycle memory
        lat = 3;
        do_reset();
        for (int i = 0; i < 100 && !(imem_req && imem_addr == 32'h8); i++) step();
        chk("t3_at8", imem_addr, 32'h8);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        q_pc.delete();
        q_in.delete();
        chk("t3_drop_addr", imem_addr, 32'h8);
        chk("t3_drop_req", 32'(imem_req), 32'd1);
        chk("t3_drop_valid", 32'(instr_valid), 32'd0);
        chk("t3_drop_instr", instr, NOP);
        wait_q(1);
        chk("t3_first_pc", q_pc[0], 32'h100);
        chk("t3_first_in", q_in[0], mem(32'h100));

        // redirect coinciding with rvalid, unaligned target
        lat = 1;
        do_reset();
        for (int i = 0; i < 100 && !(imem_rvalid && imem_addr == 32'h8); i++) step();
        chk("t4_rv8", 32'(imem_rvalid), 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h103;
        step();
        redirect = 1'b0;
        q_pc.delete();
        q_in.delete();
        chk("t4_valid", 32'(instr_valid), 32'd0);
        chk("t4_addr", imem_addr, 32'h100);
        chk("t4_req", 32'(imem_req), 32'd1);
        wait_q(1);
        chk("t4_first_pc", q_pc[0], 32'h100);

        // redirect while in HOLD
        instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 100 && !(instr_valid && !imem_req); i++) step();
        chk("t4h_hold", 32'(imem_req), 32'd0);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        chk("t4h_valid", 32'(instr_valid), 32'd0);
        chk("t4h_instr", instr, NOP);
        chk("t4h_addr", imem_addr, 32'h200);
        chk("t4h_req", 32'(imem_req), 32'd1);
        instr_ready = 1'b1;
        q_pc.delete();
        q_in.delete();
        wait_q(1);
        chk("t4h_first_pc", q_pc[0], 32'h200);
        chk("t4h_first_in", q_in[0], mem(32'h200));

        // pc wraps from FFFF_FFFC to 0
        do_reset();
        for (int i = 0; i < 50 && !v2; i++) step();
        chk("t5_valid", 32'(v2), 32'd1);
        chk("t5_ipc", pc2, 32'hFFFF_FFFC);
        chk("t5_instr", in2, 32'hFFAF_C093);
        chk("t5_wrap_addr", addr2, 32'h0);
        chk("t5_wrap_req", 32'(req2), 32'd1);

        // asynchronous reset in the middle of a request
        lat = 3;
        do_reset();
        for (int i = 0; i < 100 && !(imem_req && imem_addr == 32'h4); i++) step();
        chk("t6_at4", imem_addr, 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_req", 32'(imem_req), 32'd0);
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_valid", 32'(instr_valid), 32'd0);
        chk("t6_instr", instr, NOP);
        chk("t6_pc", instr_pc, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
